// File: rtl/dispense_sequencer.sv
// Drink command sequencer: turns the 3-bit FSM command into timed
// heater/grinder/pump/valve/coin phases with one pending-command slot.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   cmd[2:0]        000 none, 111 coffee, 110 tea, 101 tea+5 change, 100 refund
//   water_hot       heater at temperature
//   heater_on       HEAT phase
//   grinder_on      GRIND phase
//   pump_on         POUR phase
//   tea_valve       POUR phase of a tea command
//   coin_ret        REFUND phase
//   change5         CHANGE phase
//   busy            not idle
//   done            DONE phase (one cycle)
//   fault           pulse in first REFUND cycle after a heat timeout
//   cmd_drop        pulse: legal cmd lost because the pending slot was full
//   cmd_err         pulse: illegal cmd (001/010/011) ignored
module dispense_sequencer #(
  parameter int CW           = 8,
  parameter int HEAT_MAX     = 16,
  parameter int GRIND_CYCLES = 6,
  parameter int POUR_CYCLES  = 10,
  parameter int COIN_PULSE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
  input  logic       water_hot,
  output logic       heater_on,
  output logic       grinder_on,
  output logic       pump_on,
  output logic       tea_valve,
  output logic       coin_ret,
  output logic       change5,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       cmd_drop,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAT,
    S_GRIND,
    S_POUR,
    S_CHANGE,
    S_REFUND,
    S_DONE
  } state_t;

  localparam logic [2:0] C_COFFEE = 3'b111;
  localparam logic [2:0] C_TEA    = 3'b110;
  localparam logic [2:0] C_TEA5   = 3'b101;
  localparam logic [2:0] C_REFUND = 3'b100;

  localparam logic [CW-1:0] HEAT_LAST  = CW'(HEAT_MAX - 1);
  localparam logic [CW-1:0] GRIND_LAST = CW'(GRIND_CYCLES - 1);
  localparam logic [CW-1:0] POUR_LAST  = CW'(POUR_CYCLES - 1);
  localparam logic [CW-1:0] COIN_LAST  = CW'(COIN_PULSE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    cur_q, cur_d;
  logic [2:0]    pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          fault_q, fault_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;
  logic          cmd_legal;

  // Every command with the top bit set is a real drink/refund request.
  assign cmd_legal = cmd[2];

  function automatic state_t first_phase(input logic [2:0] c);
    return (c == C_REFUND) ? S_REFUND : S_HEAT;
  endfunction

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    fault_d    = 1'b0;
    drop_d     = 1'b0;
    err_d      = (cmd != 3'b000) && !cmd[2];

    unique case (state_q)
      S_IDLE: begin
        // The waiting command goes first; a new one
        // arriving now takes its place in the slot.
        if (pend_vld_q) begin
          state_d    = first_phase(pend_q);
          cur_d      = pend_q;
          pend_vld_d = cmd_legal;
          if (cmd_legal) pend_d = cmd;
        end else if (cmd_legal) begin
          state_d = first_phase(cmd);
          cur_d   = cmd;
        end
      end
      S_HEAT: begin
        if (water_hot) begin
          state_d = (cur_q == C_COFFEE) ? S_GRIND : S_POUR;
        end else if (cnt_q == HEAT_LAST) begin
          state_d = S_REFUND;
          fault_d = 1'b1;
        end
      end
      S_GRIND: begin
        if (cnt_q == GRIND_LAST) state_d = S_POUR;
      end
      S_POUR: begin
        if (cnt_q == POUR_LAST) begin
          state_d = (cur_q == C_TEA5) ? S_CHANGE : S_DONE;
        end
      end
      S_CHANGE: begin
        if (cnt_q == COIN_LAST) state_d = S_DONE;
      end
      S_REFUND: begin
        if (cnt_q == COIN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_q != S_IDLE && cmd_legal) begin
      if (!pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_d     = cmd;
      end else begin
        drop_d = 1'b1;
      end
    end

    // Held at zero in IDLE so it never free-runs.
    if (state_d != state_q || state_q == S_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_q      <= 3'b000;
      pend_q     <= 3'b000;
      pend_vld_q <= 1'b0;
      fault_q    <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      fault_q    <= fault_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign heater_on  = (state_q == S_HEAT);
  assign grinder_on = (state_q == S_GRIND);
  assign pump_on    = (state_q == S_POUR);
  assign tea_valve  = (state_q == S_POUR) &&
                      (cur_q == C_TEA || cur_q == C_TEA5);
  assign coin_ret   = (state_q == S_REFUND);
  assign change5    = (state_q == S_CHANGE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign fault      = fault_q;
  assign cmd_drop   = drop_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer: per-cycle checks of all
// outputs against hand-derived phase windows.
module tb_dispense_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] cmd;
  logic       water_hot;
  logic       heater_on, grinder_on, pump_on, tea_valve;
  logic       coin_ret, change5, busy, done;
  logic       fault, cmd_drop, cmd_err;

  int checks = 0;
  int errors = 0;

  logic [10:0] obs;
  logic [10:0] exp;

  dispense_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .water_hot  (water_hot),
    .heater_on  (heater_on),
    .grinder_on (grinder_on),
    .pump_on    (pump_on),
    .tea_valve  (tea_valve),
    .coin_ret   (coin_ret),
    .change5    (change5),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .cmd_drop   (cmd_drop),
    .cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: heater grinder pump tea coin chg5 busy done fault drop err
  assign obs = {heater_on, grinder_on, pump_on, tea_valve,
                coin_ret, change5, busy, done,
                fault, cmd_drop, cmd_err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc,
                     input logic [10:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s cyc %0d observed %b expected %b",
             tag, cyc, obs, e);
    end
  endtask

  function automatic logic in_r(input int k, input int lo,
                                input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  initial begin
    rst       = 1'b0;
    cmd       = 3'b000;
    water_hot = 1'b0;
    tick();
    tick();
    chk("reset_hold", 0, 11'b0);
    rst = 1'b1;
    tick();
    chk("reset_release", 0, 11'b0);

    // 1: coffee, hot at cycle 3
    for (int k = 0; k <= 22; k++) begin
      exp = {in_r(k, 1, 3), in_r(k, 4, 9), in_r(k, 10, 19), 1'b0,
             1'b0, 1'b0, in_r(k, 1, 20), (k == 20),
             1'b0, 1'b0, 1'b0};
      chk("coffee", k, exp);
      cmd       = (k == 0) ? 3'b111 : 3'b000;
      water_hot = (k == 3);
      tick();
    end

    // 2: tea + change, hot at cycle 1
    for (int k = 0; k <= 16; k++) begin
      exp = {(k == 1), 1'b0, in_r(k, 2, 11), in_r(k, 2, 11),
             1'b0, in_r(k, 12, 13), in_r(k, 1, 14), (k == 14),
             1'b0, 1'b0, 1'b0};
      chk("tea_change", k, exp);
      cmd       = (k == 0) ? 3'b101 : 3'b000;
      water_hot = (k == 1);
      tick();
    end

    // 3: refund
    for (int k = 0; k <= 5; k++) begin
      exp = {1'b0, 1'b0, 1'b0, 1'b0,
             in_r(k, 1, 2), 1'b0, in_r(k, 1, 3), (k == 3),
             1'b0, 1'b0, 1'b0};
      chk("refund", k, exp);
      cmd       = (k == 0) ? 3'b100 : 3'b000;
      water_hot = 1'b0;
      tick();
    end

    // 4: tea, heater never hot -> timeout refund
    for (int k = 0; k <= 21; k++) begin
      exp = {in_r(k, 1, 16), 1'b0, 1'b0, 1'b0,
             in_r(k, 17, 18), 1'b0, in_r(k, 1, 19), (k == 19),
             (k == 17), 1'b0, 1'b0};
      chk("heat_timeout", k, exp);
      cmd       = (k == 0) ? 3'b110 : 3'b000;
      water_hot = 1'b0;
      tick();
    end

    // 5: pending slot and drop
    // tea: HEAT 1-2, POUR 3-12, DONE 13, IDLE 14
    // coffee: HEAT 15, GRIND 16-21, POUR 22-31, DONE 32
    for (int k = 0; k <= 34; k++) begin
      exp = {in_r(k, 1, 2) | (k == 15), in_r(k, 16, 21),
             in_r(k, 3, 12) | in_r(k, 22, 31), in_r(k, 3, 12),
             1'b0, 1'b0, in_r(k, 1, 13) | in_r(k, 15, 32),
             (k == 13) | (k == 32),
             1'b0, (k == 7), 1'b0};
      chk("pending", k, exp);
      unique case (k)
        0:       cmd = 3'b110;
        5:       cmd = 3'b111;
        6:       cmd = 3'b100;
        default: cmd = 3'b000;
      endcase
      water_hot = (k == 2) || (k == 15);
      tick();
    end

    // 6a: illegal command
    for (int k = 0; k <= 3; k++) begin
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, (k == 1)};
      chk("cmd_err", k, exp);
      cmd       = (k == 0) ? 3'b011 : 3'b000;
      water_hot = 1'b0;
      tick();
    end

    // 6b: reset during POUR drops the pending coffee
    for (int k = 0; k <= 10; k++) begin
      exp = {(k == 1), 1'b0, in_r(k, 2, 5), in_r(k, 2, 5),
             1'b0, 1'b0, in_r(k, 1, 5), 1'b0,
             1'b0, 1'b0, 1'b0};
      chk("mid_reset", k, exp);
      cmd       = (k == 0) ? 3'b110 :
                  (k == 4) ? 3'b111 : 3'b000;
      water_hot = (k == 1);
      rst       = (k != 5);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
